// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - shared HOG pipeline types and default geometry
package hog_pkg;

  localparam int HOG_DATA_WIDTH   = 8;
  localparam int HOG_BLOCK_HEIGHT = 3;

  typedef enum logic {
    PRIME  = 1'b0,
    STREAM = 1'b1
  } line_buffer_state_t;

endpackage

// File: rtl/line_mem.sv
// rtl/line_mem.sv - one image line of pixels, async read, sync write
module line_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; priming rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_addr];

endmodule

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - stores BLOCK_HEIGHT-1 lines, emits one pixel column per accepted pixel
// Option: LINE_BUFFER_FRAME_RESET_EN re-primes at every frame end.
module line_buffer
  import hog_pkg::*;
#(
  parameter int DATA_WIDTH   = HOG_DATA_WIDTH,
  parameter int BLOCK_HEIGHT = HOG_BLOCK_HEIGHT,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int OUTPUT_WIDTH = DATA_WIDTH * BLOCK_HEIGHT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_pixels,
  output logic [BLOCK_HEIGHT-1:0] out_valid,
  input  logic [BLOCK_HEIGHT-1:0] out_ready
);

  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int NMEM  = BLOCK_HEIGHT - 1;

  line_buffer_state_t r_state;
  line_buffer_state_t w_state_next;

  logic [COL_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic                    r_out_valid;
  logic [OUTPUT_WIDTH-1:0] r_out_pixels;

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_last_col;
  logic                    w_prime_done;
  logic                    w_frame_end;
  logic [OUTPUT_WIDTH-1:0] w_column;
  logic [DATA_WIDTH-1:0]   w_rd_data [NMEM];

  assign w_accept     = in_valid && w_in_ready;
  assign w_xfer       = r_out_valid && (&out_ready);
  assign w_last_col   = (r_col == COL_W'(IMAGE_WIDTH - 1));
  assign w_prime_done = w_accept && w_last_col && (r_row == ROW_W'(BLOCK_HEIGHT - 2));
  assign w_frame_end  = w_accept && w_last_col && (r_row == ROW_W'(IMAGE_HEIGHT - 1));

  // Line k shifts into line k-1 at the same column; the newest line takes in_pixel.
  genvar k;
  generate
    for (k = 0; k < NMEM; k++) begin : g_line
      logic [DATA_WIDTH-1:0] w_wr_data;
      if (k == NMEM - 1) begin : g_top
        assign w_wr_data = in_pixel;
      end else begin : g_mid
        assign w_wr_data = w_rd_data[k+1];
      end

      line_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMAGE_WIDTH),
        .ADDR_W     (COL_W)
      ) u_line_mem (
        .clk       (clk),
        .i_addr    (r_col),
        .i_wr_en   (w_accept),
        .i_wr_data (w_wr_data),
        .o_rd_data (w_rd_data[k])
      );

      assign w_column[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[k];
    end
  endgenerate

  assign w_column[NMEM*DATA_WIDTH +: DATA_WIDTH] = in_pixel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PRIME;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b1;
    case (r_state)
      PRIME: begin
        w_in_ready = 1'b1;
        if (w_prime_done) begin
          w_state_next = STREAM;
        end
      end
      STREAM: begin
        w_in_ready = !r_out_valid || (&out_ready);
`ifdef LINE_BUFFER_FRAME_RESET_EN
        if (w_frame_end) begin
          w_state_next = PRIME;
        end
`endif
      end
      default: begin
        w_state_next = PRIME;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= (r_row == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Accept in STREAM reloads even while the old column leaves, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_pixels <= '0;
    end else if ((r_state == STREAM) && w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_pixels <= w_column;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = {BLOCK_HEIGHT{r_out_valid}};
  assign out_pixels = r_out_pixels;

endmodule

// File: doc/line_buffer.md
# line_buffer

Row-buffering stage directly upstream of the sliding-window kernel. It accepts a raster-order pixel stream (one pixel per beat, valid/ready) and stores the previous BLOCK_HEIGHT-1 image lines. For each incoming pixel it emits one vertical column of BLOCK_HEIGHT pixels, presented as per-row valid/ready lanes that match the kernel's row-parallel input.

## Interface

Parameters:
- DATA_WIDTH, 8, bits per pixel
- BLOCK_HEIGHT, 3, window rows; number of output lanes
- IMAGE_WIDTH, 640, pixels per line
- IMAGE_HEIGHT, 480, lines per frame
- OUTPUT_WIDTH, DATA_WIDTH*BLOCK_HEIGHT, width of out_pixels

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_pixel  in  DATA_WIDTH  raster-order input pixel
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block accepts in_pixel this cycle
- out_pixels  out  OUTPUT_WIDTH  column; lane i at [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 = oldest (top) line, lane BLOCK_HEIGHT-1 = current line
- out_valid  out  BLOCK_HEIGHT  per-lane valid; all bits always equal
- out_ready  in  BLOCK_HEIGHT  per-lane ready from downstream

## Operation

- Input accept: in_valid && in_ready. Output transfer: out_valid[0] && (&out_ready). A partial out_ready is not a transfer on any lane.
- Counters:
  - col: 0..IMAGE_WIDTH-1, wraps to 0.
  - row: 0..IMAGE_HEIGHT-1, increments on col wrap and wraps to 0.
  - Both advance only on input accept.
  - Widths are $clog2 of the respective dimension.
- Storage: BLOCK_HEIGHT-1 line memories L[0..BLOCK_HEIGHT-2], each IMAGE_WIDTH x DATA_WIDTH, addressed by col. On every accept: L[k][col] <= L[k+1][col] for k < BLOCK_HEIGHT-2, and L[BLOCK_HEIGHT-2][col] <= in_pixel.
- FSM, 2 states:
  - PRIME: in_ready = 1. Accepted pixels are stored and no output is produced. When the accept at col=IMAGE_WIDTH-1, row=BLOCK_HEIGHT-2 occurs, go to STREAM.
  - STREAM: in_ready = !out_valid[0] || (&out_ready). On accept, the output register loads lane k = L[k][col] (pre-write) for k < BLOCK_HEIGHT-1 and lane BLOCK_HEIGHT-1 = in_pixel, and out_valid <= all ones.
    - If a transfer occurs with no accept, out_valid <= 0.
    - Accept and transfer in the same cycle reloads the register, so there is no bubble.
- Frame end: the accept at row=IMAGE_HEIGHT-1, col=IMAGE_WIDTH-1 is handled per Configuration.
- Line memory contents are not reset; they are don't-care until rewritten by priming.

## Timing

- Reset values: out_valid = 0, out_pixels = 0, in_ready = 1, state = PRIME, col = 0, row = 0.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 column per cycle while STREAM and &out_ready stay high.
- Backpressure: out_pixels and out_valid hold stable while valid and not transferred. in_valid is not required to stay asserted.
- Reset mid-frame: next cycle shows reset values. The next frame is primed from row 0.
- Per-frame output count (FRAME_RESET_EN defined): (IMAGE_HEIGHT-BLOCK_HEIGHT+1)*IMAGE_WIDTH columns.

## Configuration

- LINE_BUFFER_FRAME_RESET_EN:
  - Defined: the final accept of a frame returns the FSM to PRIME, so windows never span two frames.
  - Undefined: the FSM stays in STREAM after first priming. The first lines of the next frame combine with the last lines of the previous frame; only the very first frame after reset primes.

## Structure

- Shared package hog_pkg holds:
  - typedef line_buffer_state_t {PRIME, STREAM}
  - default DATA_WIDTH and BLOCK_HEIGHT constants shared with the kernel
- Sub-module line_mem: one IMAGE_WIDTH x DATA_WIDTH memory, single address, asynchronous read plus synchronous write enable. Instantiated BLOCK_HEIGHT-1 times in a generate loop.

## Test plan

All scenarios use IMAGE_WIDTH=4, IMAGE_HEIGHT=4, BLOCK_HEIGHT=3, DATA_WIDTH=8, pixel value = row*16+col.

1. Reset: hold rst 2 cycles -> out_valid=3'b000, out_pixels=0, in_ready=1.
2. Priming: stream pixels 0x00..0x13 -> out_valid stays 0. Accept 0x20 -> next cycle out_valid=3'b111, lanes {0x00,0x10,0x20}. Accept 0x33 -> lanes {0x13,0x23,0x33}.
3. Backpressure: during STREAM hold out_ready=3'b011 for 5 cycles -> out_pixels held, in_ready=0, no counter change. Then out_ready=3'b111 -> transfer, and the next pixel is accepted the same cycle.
4. FRAME_RESET_EN defined: two back-to-back frames -> exactly 8 transfers per frame. The first 8 pixels of frame 2 produce no out_valid.
5. FRAME_RESET_EN undefined: after frame 1, accept 0x00 of frame 2 -> lanes {0x20,0x30,0x00}. Frame 2 yields 16 transfers.
6. Reset mid-frame at row 2, col 1, with out_valid=1 -> next cycle out_valid=0. Re-priming needs 8 accepts before the first output.
